// File: rtl/des_pkg.sv
// Shared constants for the DES key schedule: PC-1/PC-2 tables, shift schedule, FSM encoding.
package des_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_GEN  = 1'b1;

  // Bit for DES round r (MSB = round 1) set means a single-bit rotation.
  localparam logic [1:16] SHIFT1_MASK = 16'b1100_0000_1000_0001;

  localparam int unsigned PC1 [1:56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2 [1:48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

endpackage

// File: rtl/des_pc2.sv
// Combinational PC-2 selection of the 48-bit round key from the concatenated C/D halves.
module des_pc2
  import des_pkg::*;
(
  input  logic [1:56] cd,
  output logic [1:48] k
);

  for (genvar g = 1; g <= 48; g++) begin : g_pc2
    assign k[g] = cd[PC2[g]];
  end

endmodule

// File: rtl/left_rotate.sv
// 28-bit left rotate of a DES key half: shift=0 rotates by one, shift=1 by two.
module left_rotate (
  input  logic [1:28] in,
  input  logic        shift,
  output logic [1:28] out
);

  assign out = shift ? {in[3:28], in[1:2]} : {in[2:28], in[1]};

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES key schedule: loads PC-1(key), then emits one PC-2 round key per handshake,
// K1..K16 for encrypt or K16..K1 for decrypt.
module des_key_schedule
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:64] key,
  input  logic        decrypt,
  input  logic        key_valid,
  output logic        key_ready,
  output logic [1:48] subkey,
  output logic [3:0]  subkey_round,
  output logic        subkey_last,
  output logic        subkey_valid,
  input  logic        subkey_ready
);

  logic [0:0]  state_q, state_d;
  logic [1:28] c_q, c_d, d_q, d_d;
  logic [3:0]  round_q, round_d;
  logic        decrypt_q, decrypt_d;

  logic [1:28] c0, d0, rot_c_in, rot_d_in, rotl_c, rotl_d;
  logic [0:15] s1;
  logic [3:0]  round_inc;
  logic        is_idle, is_last, enc_shift2, dec_shift2;
  logic        unused_parity;

  for (genvar g = 1; g <= 28; g++) begin : g_pc1
    assign c0[g] = key[PC1[g]];
    assign d0[g] = key[PC1[g+28]];
  end

  assign unused_parity = ^{key[8], key[16], key[24], key[32],
                           key[40], key[48], key[56], key[64]};

  // s1[i] describes DES round i+1.
  assign s1        = SHIFT1_MASK;
  assign round_inc = round_q + 4'd1;
  assign is_idle   = (state_q == ST_IDLE);
  assign is_last   = decrypt_q ? (round_q == 4'd0) : (round_q == 4'd15);

  // In IDLE the encrypt rotators produce rotl(PC-1, 1), the round-1 halves.
  assign rot_c_in   = is_idle ? c0 : c_q;
  assign rot_d_in   = is_idle ? d0 : d_q;
  assign enc_shift2 = is_idle ? 1'b0 : ~s1[round_inc];
  assign dec_shift2 = ~s1[round_q];

  left_rotate u_rot_c (
    .in    (rot_c_in),
    .shift (enc_shift2),
    .out   (rotl_c)
  );

  left_rotate u_rot_d (
    .in    (rot_d_in),
    .shift (enc_shift2),
    .out   (rotl_d)
  );

  always_comb begin
    state_d   = state_q;
    c_d       = c_q;
    d_d       = d_q;
    round_d   = round_q;
    decrypt_d = decrypt_q;
    case (state_q)
      ST_IDLE: begin
        if (key_valid) begin
          state_d   = ST_GEN;
          decrypt_d = decrypt;
          if (decrypt) begin
            // Total rotation over 16 rounds is 28, so C0/D0 are also C16/D16.
            c_d     = c0;
            d_d     = d0;
            round_d = 4'd15;
          end else begin
            c_d     = rotl_c;
            d_d     = rotl_d;
            round_d = 4'd0;
          end
        end
      end
      ST_GEN: begin
        if (subkey_ready) begin
          if (is_last) begin
            state_d = ST_IDLE;
          end else if (decrypt_q) begin
            c_d     = dec_shift2 ? {c_q[27:28], c_q[1:26]} : {c_q[28], c_q[1:27]};
            d_d     = dec_shift2 ? {d_q[27:28], d_q[1:26]} : {d_q[28], d_q[1:27]};
            round_d = round_q - 4'd1;
          end else begin
            c_d     = rotl_c;
            d_d     = rotl_d;
            round_d = round_inc;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      c_q       <= '0;
      d_q       <= '0;
      round_q   <= '0;
      decrypt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      c_q       <= c_d;
      d_q       <= d_d;
      round_q   <= round_d;
      decrypt_q <= decrypt_d;
    end
  end

  des_pc2 u_pc2 (
    .cd ({c_q, d_q}),
    .k  (subkey)
  );

  assign key_ready    = is_idle;
  assign subkey_valid = ~is_idle;
  assign subkey_round = round_q;
  assign subkey_last  = ~is_idle & is_last;

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed and randomised-stall bench for des_key_schedule against the classic DES vectors
// and an independent cumulative-rotation key-schedule model.
module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:64] key = '0;
  logic        decrypt = 1'b0;
  logic        key_valid = 1'b0;
  logic        subkey_ready = 1'b0;
  logic        key_ready;
  logic [1:48] subkey;
  logic [3:0]  subkey_round;
  logic        subkey_last;
  logic        subkey_valid;

  int compared = 0;
  int mismatched = 0;

  localparam logic [1:64] KEY_A = 64'h133457799BBCDFF1;
  localparam logic [1:64] KEY_P = 64'h123556789ABDDEF0;  // KEY_A with every parity bit flipped
  localparam logic [1:64] KEY_B = 64'h0E329232EA6D0D73;

  localparam logic [47:0] KTAB [1:16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  localparam int TPC1 [1:56] = '{
    57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
    10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
    14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4
  };
  localparam int TPC2 [1:48] = '{
    14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10, 23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int TCUM [1:16] = '{1, 2, 4, 6, 8, 10, 12, 14, 15, 17, 19, 21, 23, 25, 27, 28};

  always #5 clk = ~clk;

  des_key_schedule dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key          (key),
    .decrypt      (decrypt),
    .key_valid    (key_valid),
    .key_ready    (key_ready),
    .subkey       (subkey),
    .subkey_round (subkey_round),
    .subkey_last  (subkey_last),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready)
  );

  // Round key Kr computed from scratch: PC-1, cumulative left rotation, PC-2.
  function automatic logic [1:48] ref_subkey(input logic [1:64] k, input int r);
    logic [1:28] c, d;
    logic [1:56] cd;
    logic [1:48] s;
    for (int i = 1; i <= 28; i++) begin
      c[i] = k[TPC1[i]];
      d[i] = k[TPC1[i+28]];
    end
    for (int j = 0; j < TCUM[r]; j++) begin
      c = {c[2:28], c[1]};
      d = {d[2:28], d[1]};
    end
    cd = {c, d};
    for (int i = 1; i <= 48; i++) s[i] = cd[TPC2[i]];
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_key(input logic [1:64] k, input logic dec);
    key       = k;
    decrypt   = dec;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    subkey_ready = 1'b0;
    key_valid = 1'b0;
    tick();
    tick();
    compared++;
    if (key_ready !== 1'b1) begin
      mismatched++; $display("FAIL reset key_ready: got %b expected 1", key_ready);
    end
    compared++;
    if (subkey_valid !== 1'b0) begin
      mismatched++; $display("FAIL reset subkey_valid: got %b expected 0", subkey_valid);
    end
    compared++;
    if (subkey_last !== 1'b0) begin
      mismatched++; $display("FAIL reset subkey_last: got %b expected 0", subkey_last);
    end
    compared++;
    if (subkey_round !== 4'd0) begin
      mismatched++; $display("FAIL reset subkey_round: got %0d expected 0", subkey_round);
    end
    compared++;
    if (subkey !== 48'h0) begin
      mismatched++; $display("FAIL reset subkey: got %h expected 0", subkey);
    end
    rst_n = 1'b1;
    tick();
  endtask

  // Full-rate sequence check for a known key; dec selects reversed order.
  task automatic test_known(input string name, input logic [1:64] k, input logic dec);
    logic [6:0] st, st_exp;
    int idx;
    subkey_ready = 1'b1;
    compared++;
    if (key_ready !== 1'b1) begin
      mismatched++; $display("FAIL %s idle key_ready: got %b expected 1", name, key_ready);
    end
    start_key(k, dec);
    for (int i = 1; i <= 16; i++) begin
      idx = dec ? 17 - i : i;
      compared++;
      if (subkey !== KTAB[idx]) begin
        mismatched++;
        $display("FAIL %s subkey cycle %0d: got %h expected %h", name, i, subkey, KTAB[idx]);
      end
      st     = {subkey_valid, key_ready, subkey_last, subkey_round};
      st_exp = {1'b1, 1'b0, (i == 16), 4'(idx - 1)};
      compared++;
      if (st !== st_exp) begin
        mismatched++;
        $display("FAIL %s status cycle %0d: got %b expected %b", name, i, st, st_exp);
      end
      tick();
    end
    compared++;
    if ({key_ready, subkey_valid} !== 2'b10) begin
      mismatched++;
      $display("FAIL %s end ready/valid: got %b expected 10", name, {key_ready, subkey_valid});
    end
  endtask

  task automatic test_encrypt();
    test_known("encrypt", KEY_A, 1'b0);
  endtask

  task automatic test_decrypt();
    test_known("decrypt", KEY_A, 1'b1);
  endtask

  task automatic test_parity();
    test_known("parity_enc", KEY_P, 1'b0);
    test_known("parity_dec", KEY_P, 1'b1);
  endtask

  task automatic test_key_valid_in_gen();
    logic [1:48] exp_k;
    subkey_ready = 1'b1;
    start_key(KEY_A, 1'b0);
    key       = KEY_B;
    decrypt   = 1'b1;
    key_valid = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      compared++;
      if (subkey !== KTAB[i] || subkey_round !== 4'(i - 1)) begin
        mismatched++;
        $display("FAIL busy_ignore cycle %0d: got %h/%0d expected %h/%0d",
                 i, subkey, subkey_round, KTAB[i], i - 1);
      end
      tick();
    end
    compared++;
    if (key_ready !== 1'b1) begin
      mismatched++; $display("FAIL busy_ignore first idle key_ready: got %b expected 1", key_ready);
    end
    tick();
    key_valid = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      exp_k = ref_subkey(KEY_B, 17 - i);
      compared++;
      if (subkey !== exp_k || subkey_round !== 4'(16 - i) || subkey_valid !== 1'b1) begin
        mismatched++;
        $display("FAIL back_to_back cycle %0d: got %h/%0d expected %h/%0d",
                 i, subkey, subkey_round, exp_k, 16 - i);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    subkey_ready = 1'b1;
    start_key(KEY_A, 1'b0);
    repeat (7) tick();
    compared++;
    if (subkey_round !== 4'd7 || subkey !== KTAB[8]) begin
      mismatched++;
      $display("FAIL mid_reset pre round: got %0d/%h expected 7/%h", subkey_round, subkey, KTAB[8]);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    compared++;
    if ({subkey_valid, key_ready, subkey_last} !== 3'b010) begin
      mismatched++;
      $display("FAIL mid_reset state: got %b expected 010", {subkey_valid, key_ready, subkey_last});
    end
    compared++;
    if (subkey_round !== 4'd0 || subkey !== 48'h0) begin
      mismatched++;
      $display("FAIL mid_reset regs: got %0d/%h expected 0/0", subkey_round, subkey);
    end
    test_known("after_reset", KEY_A, 1'b0);
  endtask

  task automatic test_random_stall();
    logic [1:64] k;
    logic        dec;
    logic [1:48] exp_k [1:16];
    logic [53:0] held;
    logic        prev_stall;
    int          hs, cycles, idx;
    for (int n = 0; n < 200; n++) begin
      k   = {$urandom, $urandom};
      dec = 1'($urandom_range(0, 1));
      for (int i = 1; i <= 16; i++) exp_k[i] = ref_subkey(k, i);
      subkey_ready = 1'b0;
      compared++;
      if (key_ready !== 1'b1) begin
        mismatched++; $display("FAIL stall key %0d key_ready: got %b expected 1", n, key_ready);
      end
      start_key(k, dec);
      hs = 0;
      cycles = 0;
      prev_stall = 1'b0;
      held = '0;
      while (hs < 16 && cycles < 200) begin
        if (prev_stall) begin
          compared++;
          if ({subkey_valid, subkey, subkey_round, subkey_last} !== held) begin
            mismatched++;
            $display("FAIL stall hold key %0d: got %h expected %h", n,
                     {subkey_valid, subkey, subkey_round, subkey_last}, held);
          end
        end
        subkey_ready = 1'($urandom_range(0, 1));
        if (subkey_valid && subkey_ready) begin
          idx = dec ? 16 - hs : hs + 1;
          compared++;
          if (subkey !== exp_k[idx] || subkey_round !== 4'(idx - 1) ||
              subkey_last !== (hs == 15)) begin
            mismatched++;
            $display("FAIL stall subkey key %0d hs %0d: got %h/%0d/%b expected %h/%0d/%b",
                     n, hs, subkey, subkey_round, subkey_last, exp_k[idx], idx - 1, hs == 15);
          end
          hs++;
        end
        prev_stall = subkey_valid && !subkey_ready;
        held = {subkey_valid, subkey, subkey_round, subkey_last};
        tick();
        cycles++;
      end
      compared++;
      if (hs != 16) begin
        mismatched++;
        $display("FAIL stall handshakes key %0d: got %0d expected 16 (cycle budget)", n, hs);
      end
      compared++;
      if ({subkey_valid, key_ready} !== 2'b01) begin
        mismatched++;
        $display("FAIL stall end key %0d valid/ready: got %b expected 01",
                 n, {subkey_valid, key_ready});
      end
    end
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_decrypt();
    test_parity();
    test_key_valid_in_gen();
    test_reset_mid();
    test_random_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
